// File: rtl/rf_read_port_arbiter.sv
// rf_read_port_arbiter
// Shares one register-file read port among NREQ requesters. Requests are
// arbitrated round-robin. The winner's address is driven onto rf_sel and held
// for SETTLE_CYC cycles so the mux tree can settle. The word is then captured
// and returned, tagged with the requester ID.
// Optional build macro: ARB_STATS_EN adds grant/wait statistics counters.

module rf_read_port_arbiter #(
  parameter int NREQ       = 4,
  parameter int IDW        = 2,
  parameter int DW         = 32,
  parameter int SETTLE_CYC = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*5-1:0] addr,
  output logic [NREQ-1:0]   gnt,
  output logic [4:0]        rf_sel,
  input  logic [DW-1:0]     rf_data,
  output logic [DW-1:0]     rdata,
  output logic              rdata_valid,
  output logic [IDW-1:0]    rdata_id,
  output logic              busy
`ifdef ARB_STATS_EN
  ,
  input  logic              stats_clr,
  output logic [15:0]       grant_count,
  output logic [15:0]       wait_count
`endif
);

  typedef enum logic {
    IDLE,
    SETTLE
  } state_t;

  state_t         state;
  state_t         state_next;
  logic [IDW-1:0] ptr;
  logic [IDW-1:0] cur_id;
  logic [3:0]     cnt;

  logic           win_found;
  logic [IDW-1:0] win;
  logic [4:0]     win_addr;
  logic           grant_fire;
  logic           capture_fire;

  // Round-robin pick: scan offsets from the far end down to 0 so that the
  // requester closest to ptr (offset 0 first) is the one left standing.
  always_comb begin
    win_found = 1'b0;
    win       = '0;
    win_addr  = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      for (int i = 0; i < NREQ; i++) begin
        if ((i == ((int'(ptr) + k) % NREQ)) && req[i]) begin
          win_found = 1'b1;
          win       = IDW'(i);
          win_addr  = addr[5*i +: 5];
        end
      end
    end
  end

  assign grant_fire   = (state == IDLE) && win_found;
  assign capture_fire = (state == SETTLE) && (cnt == 4'd0);
  assign busy         = (state == SETTLE);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: leave IDLE on a grant, return once the word is captured.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (grant_fire) state_next = SETTLE;
      SETTLE:  if (capture_fire) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: grant pulse, select hold, settle countdown and word capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gnt         <= '0;
      rf_sel      <= '0;
      cur_id      <= '0;
      ptr         <= '0;
      cnt         <= '0;
      rdata       <= '0;
      rdata_valid <= 1'b0;
      rdata_id    <= '0;
    end else begin
      gnt         <= '0;
      rdata_valid <= 1'b0;
      if (grant_fire) begin
        gnt         <= NREQ'(1) << win;
        rf_sel      <= win_addr;
        cur_id      <= win;
        ptr         <= IDW'((int'(win) + 1) % NREQ);
        cnt         <= 4'(SETTLE_CYC - 1);
      end else if (state == SETTLE) begin
        if (cnt != 4'd0) begin
          cnt <= cnt - 4'd1;
        end else begin
          rdata       <= rf_data;
          rdata_id    <= cur_id;
          rdata_valid <= 1'b1;
        end
      end
    end
  end

`ifdef ARB_STATS_EN
  // Statistics: count visible grant pulses and cycles where someone is
  // requesting but no grant is showing; both saturate, clear wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant_count <= '0;
      wait_count  <= '0;
    end else if (stats_clr) begin
      grant_count <= '0;
      wait_count  <= '0;
    end else begin
      if ((|gnt) && (grant_count != 16'hFFFF)) begin
        grant_count <= grant_count + 16'd1;
      end
      if ((|req) && !(|gnt) && (wait_count != 16'hFFFF)) begin
        wait_count <= wait_count + 16'd1;
      end
    end
  end
`endif

endmodule
